// File: rtl/lc3b_types.sv
// Shared LC-3b memory-port types: data word, write lane mask and the responder FSM states.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        MR_IDLE,
        MR_BUSY,
        MR_RESP
    } lc3b_memresp_state;

endpackage

// File: rtl/lc3b_byte_ram.sv
// Word-organised RAM with two independently writable byte lanes.
// Synchronous write and combinational read. Contents are not reset.
module lc3b_byte_ram
    import lc3b_types::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  lc3b_mem_wmask     be_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  lc3b_word          wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output lc3b_word          rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    lc3b_word mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            if (be_i[0]) mem_q[waddr_i][7:0]  <= wdata_i[7:0];
            if (be_i[1]) mem_q[waddr_i][15:8] <= wdata_i[15:8];
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lc3b_mem_responder.sv
// Memory-side responder for the LC-3b mem_read/mem_write/mem_resp handshake with fixed latency.
// Optional handshake checker enabled by defining LC3B_MEM_PROTOCOL_CHECK_EN.
module lc3b_mem_responder
    import lc3b_types::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_read,
    input  logic          mem_write,
    input  lc3b_mem_wmask mem_byte_enable,
    input  lc3b_word      mem_address,
    input  lc3b_word      mem_wdata,
    output logic          mem_resp,
    output lc3b_word      mem_rdata,
    output logic          protocol_err
);

    localparam int unsigned     CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    lc3b_memresp_state state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] idx_q, rd_idx;
    lc3b_word          wdata_q, rdata_q, rdata_d, ram_rdata;
    lc3b_mem_wmask     be_q;
    logic              wr_q, resp_q, resp_d;
    logic              req, accept, ram_we, rd_is_read;
    logic              unused_addr_bits;

    assign req              = mem_read | mem_write;
    assign accept           = (state_q == MR_IDLE) && req;
    assign unused_addr_bits = ^{mem_address[0], mem_address[15:ADDR_W+1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= MR_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            MR_IDLE: begin
                if (req) begin
                    if (LATENCY == 1) begin
                        state_d = MR_RESP;
                    end else begin
                        state_d = MR_BUSY;
                        count_d = CNT_LOAD;
                    end
                end
            end
            MR_BUSY: begin
                count_d = count_q - CNT_W'(1);
                if (count_q <= CNT_W'(1)) state_d = MR_RESP;
            end
            MR_RESP: state_d = MR_IDLE;
            default: state_d = MR_IDLE;
        endcase
    end

    // With LATENCY==1 the read happens on the accepting edge, so the live address is used in IDLE.
    always_comb begin
        rd_idx     = idx_q;
        rd_is_read = !wr_q;
        resp_d     = 1'b0;
        rdata_d    = rdata_q;
        ram_we     = 1'b0;
        if (state_q == MR_IDLE) begin
            rd_idx     = mem_address[ADDR_W:1];
            rd_is_read = !mem_write;
        end
        if (state_d == MR_RESP) begin
            resp_d = 1'b1;
            if ((state_q != MR_RESP) && rd_is_read) rdata_d = ram_rdata;
        end
        if ((state_q == MR_RESP) && wr_q) ram_we = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            count_q <= count_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            if (accept) begin
                idx_q   <= mem_address[ADDR_W:1];
                wdata_q <= mem_wdata;
                be_q    <= mem_byte_enable;
                wr_q    <= mem_write;
            end
        end
    end

    lc3b_byte_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .be_i    (be_q),
        .waddr_i (idx_q),
        .wdata_i (wdata_q),
        .raddr_i (rd_idx),
        .rdata_o (ram_rdata)
    );

    assign mem_resp  = resp_q;
    assign mem_rdata = rdata_q;

`ifdef LC3B_MEM_PROTOCOL_CHECK_EN
    lc3b_word addr_q;
    logic     err_q, err_d, in_txn;

    // Sticky flag: conflicting request kinds at acceptance, or any request change while in flight.
    always_comb begin
        err_d  = err_q;
        in_txn = (state_q == MR_BUSY) || (state_q == MR_RESP);
        if (accept && mem_read && mem_write) err_d = 1'b1;
        if (in_txn) begin
            if ((wr_q ? !mem_write : !mem_read) || (mem_write != wr_q) ||
                (mem_address != addr_q) || (mem_wdata != wdata_q) ||
                (mem_byte_enable != be_q)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            err_q <= err_d;
            if (accept) addr_q <= mem_address;
        end
    end

    assign protocol_err = err_q;
`else
    assign protocol_err = 1'b0;
`endif

endmodule
